// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the pipelined SECDED decoder.
// Covers the check-bit count, power-of-two position tests and data-bit placement.
package hamming_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        SEC  = 2'b01,
        DED  = 2'b10,
        INV  = 2'b11
    } err_flag_t;

    function automatic int par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p = p + 1;
        return p;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Code-word bit index carrying data bit j: the j-th non-power-of-two Hamming position.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < 256; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j) pos = i - 1;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended Hamming word.
// Bit i of the code (i < N) sits at Hamming position i+1; bit N is overall parity.
module hamming_syndrome import hamming_pkg::*; #(
    parameter int  DATA_W = 4,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int N      = DATA_W + PAR_W
) (
    input  logic [N:0]       code,
    output logic [PAR_W-1:0] syn,
    output logic             ov
);

    always_comb begin
        syn = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (((i + 1) & (1 << k)) != 0) syn[k] = syn[k] ^ code[i];
            end
        end
    end

    assign ov = ^code;

endmodule

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready streams and saturating error counters.
// Stage 1 captures the word with its syndrome; stage 2 holds the classified, corrected word.
module hamming_secded_decoder_pipe import hamming_pkg::*; #(
    parameter int  DATA_W = 4,
    parameter int  CNT_W  = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int N      = DATA_W + PAR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_cnt,
    input  logic              correct_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N:0]        code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N:0]        code_out,
    output logic [DATA_W-1:0] data_out,
    output logic [PAR_W-1:0]  err_loc,
    output logic [1:0]        err_flag,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    logic             s1_adv;
    logic             s2_adv;
    logic [PAR_W-1:0] syn_c;
    logic             ov_c;
    err_flag_t        flag_c;
    logic [N:0]       fix_c;

    logic             vld_p1;
    logic [N:0]       code_p1;
    logic [PAR_W-1:0] syn_p1;
    logic             ov_p1;
    logic             cen_p1;

    logic             vld_p2;
    logic [N:0]       code_p2;
    err_flag_t        flag_p2;
    logic [PAR_W-1:0] loc_p2;

    logic             fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .code (code_in),
        .syn  (syn_c),
        .ov   (ov_c)
    );

    // Stage 1: capture word, syndrome, overall parity and the per-word correction enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            code_p1 <= '0;
            syn_p1  <= '0;
            ov_p1   <= 1'b0;
            cen_p1  <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                code_p1 <= code_in;
                syn_p1  <= syn_c;
                ov_p1   <= ov_c;
                cen_p1  <= correct_en;
            end
        end
    end

    // Syndrome zero with odd parity means the overall parity bit itself flipped
    always_comb begin
        flag_c = NONE;
        fix_c  = '0;
        if (ov_p1) begin
            if (int'(syn_p1) > N) begin
                flag_c = INV;
            end else begin
                flag_c = SEC;
                for (int i = 0; i <= N; i++)
                    fix_c[i] = (syn_p1 == '0) ? (i == N) : (int'(syn_p1) == i + 1);
            end
        end else if (syn_p1 != '0) begin
            flag_c = DED;
        end
    end

    // Stage 2: classified and (optionally) corrected word presented to the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            code_p2 <= '0;
            flag_p2 <= NONE;
            loc_p2  <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                code_p2 <= cen_p1 ? (code_p1 ^ fix_c) : code_p1;
                flag_p2 <= flag_c;
                loc_p2  <= (flag_c == SEC) ? syn_p1 : '0;
            end
        end
    end

    assign fire = vld_p2 && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (clr_cnt) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (fire) begin
            if (flag_p2 == SEC) sec_cnt <= sat_inc(sec_cnt);
            if (flag_p2 == DED || flag_p2 == INV) ded_cnt <= sat_inc(ded_cnt);
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign data_out[j] = code_p2[data_pos(j)];
    end

    assign out_valid = vld_p2;
    assign code_out  = code_p2;
    assign err_loc   = loc_p2;
    assign err_flag  = flag_p2;

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Directed bench: a DATA_W=4/CNT_W=8 decoder and a DATA_W=5/CNT_W=2 decoder on one clock.
module tb_hamming_secded_decoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic       rst_n, clr_cnt, correct_en, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] code_in, code_out;
    logic [3:0] data_out;
    logic [2:0] err_loc;
    logic [1:0] err_flag;
    logic [7:0] sec_cnt, ded_cnt;

    logic       f_rst_n, f_clr_cnt, f_correct_en, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [9:0] f_code_in, f_code_out;
    logic [4:0] f_data_out;
    logic [3:0] f_err_loc;
    logic [1:0] f_err_flag;
    logic [1:0] f_sec_cnt, f_ded_cnt;

    logic [7:0] bp_in  [8] = '{8'h55, 8'h45, 8'hD5, 8'h56, 8'h00, 8'h01, 8'hFF, 8'h7F};
    logic [7:0] bp_exp [8] = '{8'h55, 8'h55, 8'h55, 8'h56, 8'h00, 8'h00, 8'hFF, 8'hFF};
    int         acc, dlv;
    bit         stall;
    logic [7:0] held;

    hamming_secded_decoder_pipe #(.DATA_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr_cnt(clr_cnt), .correct_en(correct_en),
        .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
        .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
        .data_out(data_out), .err_loc(err_loc), .err_flag(err_flag),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    hamming_secded_decoder_pipe #(.DATA_W(5), .CNT_W(2)) dut5 (
        .clk(clk), .rst_n(f_rst_n), .clr_cnt(f_clr_cnt), .correct_en(f_correct_en),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .code_in(f_code_in),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .code_out(f_code_out),
        .data_out(f_data_out), .err_loc(f_err_loc), .err_flag(f_err_flag),
        .sec_cnt(f_sec_cnt), .ded_cnt(f_ded_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xact4(input string tag, input logic [7:0] c, input logic cen,
                         input logic [7:0] ec, input logic [3:0] ed,
                         input logic [1:0] ef, input logic [2:0] el);
        @(negedge clk);
        code_in = c; correct_en = cen; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_code"}, code_out, ec);
        chk({tag, "_data"}, data_out, ed);
        chk({tag, "_flag"}, err_flag, ef);
        chk({tag, "_loc"}, err_loc, el);
    endtask

    task automatic xact5(input string tag, input logic [9:0] c, input logic cen,
                         input logic [9:0] ec, input logic [4:0] ed,
                         input logic [1:0] ef, input logic [3:0] el);
        @(negedge clk);
        f_code_in = c; f_correct_en = cen; f_in_valid = 1'b1; f_out_ready = 1'b1;
        @(negedge clk);
        f_in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, f_out_valid, 1);
        chk({tag, "_code"}, f_code_out, ec);
        chk({tag, "_data"}, f_data_out, ed);
        chk({tag, "_flag"}, f_err_flag, ef);
        chk({tag, "_loc"}, f_err_loc, el);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clr_cnt = 1'b0; correct_en = 1'b1; in_valid = 1'b0;
        out_ready = 1'b1; code_in = '0;
        f_rst_n = 1'b0; f_clr_cnt = 1'b0; f_correct_en = 1'b1; f_in_valid = 1'b0;
        f_out_ready = 1'b1; f_code_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_code", code_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_flag", err_flag, 0);
        chk("rst_loc", err_loc, 0);
        chk("rst_sec", sec_cnt, 0);
        chk("rst_ded", ded_cnt, 0);
        chk("rst_rdy", in_ready, 1);
        rst_n = 1'b1; f_rst_n = 1'b1;

        xact4("clean", 8'h55, 1'b1, 8'h55, 4'hB, 2'b00, 3'd0);
        @(negedge clk);
        chk("clean_sec", sec_cnt, 0);
        chk("clean_ded", ded_cnt, 0);

        xact4("sec5", 8'h45, 1'b1, 8'h55, 4'hB, 2'b01, 3'd5);
        @(negedge clk);
        chk("sec5_cnt", sec_cnt, 1);
        xact4("secov", 8'hD5, 1'b1, 8'h55, 4'hB, 2'b01, 3'd0);
        @(negedge clk);
        chk("secov_cnt", sec_cnt, 2);

        xact4("ded", 8'h56, 1'b1, 8'h56, 4'hB, 2'b10, 3'd0);
        @(negedge clk);
        chk("ded_cnt", ded_cnt, 1);
        chk("ded_sec", sec_cnt, 2);
        xact4("nocorr", 8'h45, 1'b0, 8'h45, 4'h9, 2'b01, 3'd5);
        @(negedge clk);
        chk("nocorr_sec", sec_cnt, 3);

        acc = 0; dlv = 0; stall = 0; held = '0;
        for (int c = 0; c < 64 && dlv < 8; c++) begin
            @(negedge clk);
            if (stall) begin
                chk("bp_hold_vld", out_valid, 1);
                chk("bp_hold_code", code_out, held);
            end
            out_ready  = (c % 2 == 0);
            in_valid   = (acc < 8);
            code_in    = bp_in[(acc < 8) ? acc : 0];
            correct_en = 1'b1;
            #1;
            chk("bp_rdy", in_ready, (out_ready || (acc - dlv) < 2));
            stall = out_valid && !out_ready;
            held  = code_out;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_out%0d", dlv), code_out, bp_exp[dlv]);
                dlv++;
            end
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_done", dlv, 8);
        @(negedge clk);
        chk("bp_sec", sec_cnt, 7);
        chk("bp_ded", ded_cnt, 2);

        @(negedge clk);
        code_in = 8'h45; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_vld", out_valid, 0);
        chk("mid_code", code_out, 0);
        chk("mid_sec", sec_cnt, 0);
        chk("mid_ded", ded_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_post_vld", out_valid, 0);
        chk("mid_post_rdy", in_ready, 1);

        xact5("inv", 10'h288, 1'b1, 10'h288, 5'h00, 2'b11, 4'd0);
        @(negedge clk);
        chk("inv_ded", f_ded_cnt, 1);
        chk("inv_sec", f_sec_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            f_code_in = 10'h001; f_in_valid = 1'b1; f_out_ready = 1'b1;
            #1;
            chk("sat_rdy", f_in_ready, 1);
        end
        @(negedge clk);
        f_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_sec", f_sec_cnt, 3);
        chk("sat_ded", f_ded_cnt, 1);
        chk("sat_code", f_code_out, 10'h000);
        chk("sat_loc", f_err_loc, 4'd1);

        @(negedge clk);
        f_code_in = 10'h001; f_in_valid = 1'b1;
        @(negedge clk);
        f_in_valid = 1'b0;
        @(negedge clk);
        chk("clr_vld", f_out_valid, 1);
        chk("clr_flag", f_err_flag, 2'b01);
        f_clr_cnt = 1'b1;
        @(negedge clk);
        f_clr_cnt = 1'b0;
        chk("clr_sec", f_sec_cnt, 0);
        chk("clr_ded", f_ded_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
